// File: rtl/mux4_op_pipe.sv
// Registered 4-way operand selector with valid/ready handshake and a 1-entry output register.
// It computes din0, din1, din0+din1 or din0-din1 on signed operands, with overflow detection and optional saturation.
module mux4_op_pipe #(
    parameter int WIDTH = 3,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic             ovf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic [1:0]       out_sel,
    output logic             ovf_sticky
);

    logic [1:0]       scan_q;
    logic [1:0]       eff_sel;
    logic             accept;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign eff_sel  = auto_mode ? scan_q : sel;
    assign a_ext    = {din0[WIDTH-1], din0};
    assign b_ext    = {din1[WIDTH-1], din1};

    always_comb begin
        sum_ext = '0;
        res_ovf = 1'b0;
        res     = '0;
        case (eff_sel)
            2'd0: res = din0;
            2'd1: res = din1;
            default: begin
                sum_ext = (eff_sel == 2'd2) ? (a_ext + b_ext) : (a_ext - b_ext);
                // The extra sign bit disagreeing with the result MSB means the value left the WIDTH-bit range.
                res_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                if (res_ovf && (SAT != 0))
                    res = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    res = sum_ext[WIDTH-1:0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            dout       <= '0;
            ovf        <= 1'b0;
            out_sel    <= 2'd0;
            ovf_sticky <= 1'b0;
            scan_q     <= 2'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                dout      <= res;
                ovf       <= res_ovf;
                out_sel   <= eff_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && res_ovf)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;

            if (!auto_mode)
                scan_q <= 2'd0;
            else if (accept)
                scan_q <= scan_q + 2'd1;
        end
    end

endmodule
